// File: rtl/logic_cmd_queue_pkg.sv
// ============================================================================
// Module      : logic_cmd_pkg
// Description : Shared types and constants for the logic command queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package logic_cmd_pkg;

    localparam int WIDTH = 8;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_NOTA = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam logic [2:0] OP_NOTB = 3'd6;
    localparam logic [2:0] OP_NAND = 3'd7;

    // Operands keep the logic unit's ascending bit order.
    typedef struct packed {
        logic               chain;
        logic [2:0]         s;
        logic [0:WIDTH-1]   a;
        logic [0:WIDTH-1]   b;
    } logic_cmd_t;

    typedef enum logic [0:0] {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

endpackage

`default_nettype wire

// File: rtl/logic_cmd_queue_if.sv
// ============================================================================
// Module      : logic_cmd_queue_if
// Description : Command, logic-unit and result signals of the command queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface logic_cmd_queue_if
    import logic_cmd_pkg::*;
#(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic               in_valid;
    logic               in_ready;
    logic [0:WIDTH-1]   in_a;
    logic [0:WIDTH-1]   in_b;
    logic [2:0]         in_s;
    logic               in_chain;

    logic [0:WIDTH-1]   lu_a;
    logic [0:WIDTH-1]   lu_b;
    logic [2:0]         lu_s;
    logic [0:WIDTH-1]   lu_o;

    logic               out_valid;
    logic               out_ready;
    logic [0:WIDTH-1]   out_o;
    logic [2:0]         out_s;
    logic [CW-1:0]      count;

    modport slave (
        input  in_valid, in_a, in_b, in_s, in_chain, lu_o, out_ready,
        output in_ready, lu_a, lu_b, lu_s, out_valid, out_o, out_s, count
    );

    modport master (
        output in_valid, in_a, in_b, in_s, in_chain, lu_o, out_ready,
        input  in_ready, lu_a, lu_b, lu_s, out_valid, out_o, out_s, count
    );

endinterface

`default_nettype wire

// File: rtl/logic_cmd_queue_fifo.sv
// ============================================================================
// Module      : logic_cmd_fifo
// Description : Circular command FIFO with a separate occupancy counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module logic_cmd_fifo
    import logic_cmd_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = $clog2(DEPTH)
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    input  wire logic           i_push,
    input  wire logic_cmd_t     i_push_data,
    input  wire logic           i_pop,
    output      logic_cmd_t     o_head,
    output      logic [CW-1:0]  o_count,
    output      logic           o_full,
    output      logic           o_empty
);

    logic_cmd_t     r_mem [DEPTH];
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;
    logic           w_push;
    logic           w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally at PW bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/logic_cmd_queue.sv
// ============================================================================
// Module      : logic_cmd_queue
// Description : Buffered, back-pressured issue stage for the 8-bit logic unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module logic_cmd_queue
    import logic_cmd_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    logic_cmd_queue_if.slave    bus
);

    localparam int CW = $clog2(DEPTH + 1);

    logic_cmd_t         w_push_data;
    logic_cmd_t         w_head;
    logic [CW-1:0]      w_count;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    out_state_t         r_state;
    out_state_t         w_state_nxt;
    logic [0:WIDTH-1]   r_acc;
    logic [0:WIDTH-1]   r_out_o;
    logic [2:0]         r_out_s;

    assign w_push_data = '{chain: bus.in_chain, s: bus.in_s, a: bus.in_a, b: bus.in_b};
    assign w_push      = bus.in_valid && !w_full;

    logic_cmd_fifo #(
        .DEPTH       (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_count),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    // Operands go to zero while empty so the unit sees a quiet input.
    assign bus.lu_a      = w_empty ? '0 : (w_head.chain ? r_acc : w_head.a);
    assign bus.lu_b      = w_empty ? '0 : w_head.b;
    assign bus.lu_s      = w_empty ? '0 : w_head.s;
    assign bus.in_ready  = !w_full;
    assign bus.count     = w_count;
    assign bus.out_valid = (r_state == OUT_FULL);
    assign bus.out_o     = r_out_o;
    assign bus.out_s     = r_out_s;

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            OUT_EMPTY: begin
                w_pop = !w_empty;
                if (w_pop) begin
                    w_state_nxt = OUT_FULL;
                end
            end
            OUT_FULL: begin
                w_pop = !w_empty && bus.out_ready;
                if (bus.out_ready && !w_pop) begin
                    w_state_nxt = OUT_EMPTY;
                end
            end
            default: w_state_nxt = OUT_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= OUT_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_out_o <= '0;
            r_out_s <= '0;
        end else if (w_pop) begin
            r_acc   <= bus.lu_o;
            r_out_o <= bus.lu_o;
            r_out_s <= w_head.s;
        end
    end

endmodule

`default_nettype wire

// File: doc/logic_cmd_queue.md
# logic_cmd_queue

Upstream issue stage for the 8-bit logic unit: accepts logic commands over a valid/ready handshake and buffers them in a small FIFO. It presents one command per cycle to the logic unit's `a`/`b`/`s` inputs, captures the unit's combinational result into a registered output stage, and keeps the last result in an accumulator so a command can chain on it. It decouples command producers from result consumers and gives the combinational logic unit a pipelined, back-pressured wrapper.

## Interface
- `DEPTH`, 4, FIFO entries; power of two, ≥ 2.
- `WIDTH`, 8, operand/result width; matches the logic unit.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  command present.
- `in_ready`  out  1  queue can accept (`count < DEPTH`).
- `in_a`, `in_b`  in  WIDTH  operands.
- `in_s`  in  3  opcode, unsigned value 0–7.
- `in_chain`  in  1  replace operand a with the accumulator at issue.
- `lu_a`, `lu_b`  out  WIDTH  to the logic unit operand inputs.
- `lu_s`  out  3  to the logic unit select.
- `lu_o`  in  WIDTH  logic unit result, combinational from `lu_*`.
- `out_valid`  out  1  result register holds data.
- `out_ready`  in  1  consumer takes the result.
- `out_o`  out  WIDTH  registered result.
- `out_s`  out  3  opcode that produced `out_o`.
- `count`  out  $clog2(DEPTH+1)  FIFO occupancy.

Operand vectors are declared ascending `[0:WIDTH-1]`, matching the logic unit ports.

## Operation
- **Push:** happens when `in_valid && in_ready`. The entry {chain, s, a, b} is written at the tail.
- **No pass-through:** `in_ready` is 0 when full, even if a pop happens in the same cycle.
- **Head drive:** `lu_a = head.chain ? acc : head.a`, `lu_b = head.b`, `lu_s = head.s`.
  - All three are combinational from the head entry.
  - When the FIFO is empty they are driven to all zeros.
- **Pop (issue):** the condition is `count != 0 && (!out_valid || out_ready)`. On that edge:
  - `out_o <= lu_o`, `out_s <= head.s`, `out_valid <= 1`;
  - `acc <= lu_o`;
  - the head advances.
- **Drain:** when `out_valid && out_ready` and no pop occurs, `out_valid <= 0`. `out_o` and `out_s` hold their last values.
- **Simultaneous push and pop:** `count` is unchanged and both pointers advance.
- **Pointers:** wrap modulo DEPTH. `count` is tracked separately, so full and empty are unambiguous.
- **Accumulator:** updated only on pop. A chained command uses the result of the immediately preceding issued command, including back-to-back issue.
- **Opcodes:**

  | Value | Operation |
  |---|---|
  | 0 | AND |
  | 1 | OR |
  | 2 | XOR |
  | 3 | NOT A |
  | 4 | NOR |
  | 5 | XNOR |
  | 6 | NOT B |
  | 7 | NAND |

  The block passes `s` through unmodified.
- **Output register state:**
  - EMPTY → FULL on pop.
  - FULL → FULL on pop with `out_ready`, or when held without `out_ready`.
  - FULL → EMPTY on `out_ready` with no pop.

## Timing
- **Reset:** while `rst_n` = 0, asynchronously:
  - `count` = 0 and the pointers are 0;
  - `out_valid` = 0, `out_o` = 0, `out_s` = 0;
  - `acc` = 0;
  - `lu_*` = 0;
  - `in_ready` = 1.
- **Reset mid-operation:** flushes all queued commands and any pending result with no output. A chained command issued first after reset uses `acc` = 0.
- **Latency:** a command accepted at edge N into an empty queue, with the output stage empty, appears as `out_valid` = 1 after edge N+1.
- **Throughput:** one command per cycle with `out_ready` held at 1.
- **Backpressure:** with `out_ready` = 0, the block holds DEPTH+1 commands (one in the output register). `out_o` and `out_s` are stable while `out_valid && !out_ready`.
- `in_ready` and `count` are registered-state derived, with no combinational path from `in_valid`.

## Structure
- **Package `logic_cmd_pkg`:**
  - opcode localparams `OP_AND` … `OP_NAND` (values 0–7);
  - `WIDTH` default;
  - packed struct `logic_cmd_t` {chain, s[2:0], a, b}.
- **Sub-module `logic_cmd_fifo`:**
  - parameterized DEPTH, storing `logic_cmd_t`;
  - ports: push, pop, head, count, full, empty.
- The top level holds the pop logic, operand mux, accumulator and output register.
- The logic unit is instantiated outside the block and connects through `lu_*`.

## Test plan
- **Reset:** assert `rst_n` low mid-stream with 3 queued → `count` = 0, `out_valid` = 0, `out_o` = 0, `in_ready` = 1 immediately. Nothing emerges after release.
- **Opcode sweep:** a = 0xCA, b = 0x69, s = 0..7 back-to-back, `out_ready` = 1 → `out_o` = 0x48, 0xEB, 0xA3, 0x35, 0x14, 0x5C, 0x96, 0xB7 on consecutive cycles. The first result appears one cycle after the first accept, and `out_s` matches each opcode.
- **Chain:** AND(0xCA, 0x69), then XOR with chain = 1, b = 0xFF → results 0x48, then 0xB7.
- **Backpressure:** `out_ready` = 0, push 6 commands.
  - 5 are accepted; `count` = 4 and `in_ready` = 0.
  - `out_o` stays stable.
  - Raise `out_ready` → the 5 results drain in order, one per cycle.
- **Simultaneous push and pop:** queue at 2, push while draining → `count` stays 2 and ordering is preserved across pointer wrap (≥ 2·DEPTH commands).
- **Chain after reset:** chained NOT B with b = 0x0F first after reset → `lu_a` = 0x00 and `out_o` = 0xF0.
